// File: rtl/lsu.sv
// Load/store unit: one word-aligned memory transaction (or a pass-through
// value) per operation, handed to writeback aligned and extended.
module lsu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_is_load,
    input  logic             in_is_store,
    input  logic [2:0]       in_funct3,
    input  logic [WIDTH-1:0] in_addr,
    input  logic [WIDTH-1:0] in_wdata,
    input  logic [4:0]       in_rd,
    output logic             mem_req_valid,
    input  logic             mem_req_ready,
    output logic [WIDTH-1:0] mem_req_addr,
    output logic             mem_req_wen,
    output logic [WIDTH-1:0] mem_req_wdata,
    output logic [3:0]       mem_req_wmask,
    input  logic             mem_rsp_valid,
    input  logic [WIDTH-1:0] mem_rsp_rdata,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [4:0]       out_rd,
    output logic             out_wen,
    output logic             out_fault
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t     state;
    state_t     state_next;
    logic       is_load_q;
    logic [2:0] funct3_q;
    logic [1:0] offset_q;

    // Decode of the incoming operation (only meaningful while in IDLE).
    logic       mem_op;
    logic       both_ops;
    logic       funct3_legal;
    logic       misaligned;
    logic       fault;
    logic       go_bus;
    logic       accept;

    assign in_ready = (state == IDLE);
    assign accept   = in_ready && in_valid;
    assign mem_op   = in_is_load ^ in_is_store;
    assign both_ops = in_is_load & in_is_store;

    assign funct3_legal = in_is_load
        ? (in_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101})
        : (in_funct3 inside {3'b000, 3'b001, 3'b010});

    assign misaligned = ((in_funct3[1:0] == 2'b01) && in_addr[0]) ||
                        ((in_funct3[1:0] == 2'b10) && (in_addr[1:0] != 2'b00));

    assign fault  = both_ops || (mem_op && (!funct3_legal || misaligned));
    assign go_bus = mem_op && !fault;

    logic [3:0]       store_mask;
    logic [WIDTH-1:0] store_data;
    logic [7:0]       load_byte;
    logic [15:0]      load_half;
    logic [WIDTH-1:0] load_data;

    // Store lane placement: replicate data, enable only the addressed bytes.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        store_mask = 4'b1111;
        store_data = in_wdata;
        case (in_funct3[1:0])
            2'b00: begin
                store_mask = 4'b0001 << in_addr[1:0];
                store_data = {4{in_wdata[7:0]}};
            end
            2'b01: begin
                store_mask = 4'b0011 << in_addr[1:0];
                store_data = {2{in_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    // Load lane extraction and sign/zero extension of the response word.
    always_comb begin
        load_byte = mem_rsp_rdata[{offset_q, 3'b000} +: 8];
        load_half = mem_rsp_rdata[{offset_q[1], 4'b0000} +: 16];
        load_data = mem_rsp_rdata;
        case (funct3_q)
            3'b000:  load_data = {{(WIDTH-8){load_byte[7]}}, load_byte};
            3'b001:  load_data = {{(WIDTH-16){load_half[15]}}, load_half};
            3'b100:  load_data = {{(WIDTH-8){1'b0}}, load_byte};
            3'b101:  load_data = {{(WIDTH-16){1'b0}}, load_half};
            default: load_data = mem_rsp_rdata;
        endcase
    end

    // FSM state register.
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state logic: one operation in flight, no overlap.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (in_valid)      state_next = go_bus ? REQ : DONE;
            REQ:  if (mem_req_ready) state_next = WAIT;
            WAIT: if (mem_rsp_valid) state_next = DONE;
            DONE: if (out_ready)     state_next = IDLE;
            default:                 state_next = IDLE;
        endcase
    end

    // Registered bus request, writeback result and captured operation fields.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            is_load_q     <= 1'b0;
            funct3_q      <= '0;
            offset_q      <= '0;
            mem_req_valid <= 1'b0;
            mem_req_addr  <= '0;
            mem_req_wen   <= 1'b0;
            mem_req_wdata <= '0;
            mem_req_wmask <= '0;
            out_valid     <= 1'b0;
            out_data      <= '0;
            out_rd        <= '0;
            out_wen       <= 1'b0;
            out_fault     <= 1'b0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    is_load_q <= in_is_load;
                    funct3_q  <= in_funct3;
                    offset_q  <= in_addr[1:0];
                    out_rd    <= in_rd;
                    if (go_bus) begin
                        mem_req_valid <= 1'b1;
                        mem_req_addr  <= {in_addr[WIDTH-1:2], 2'b00};
                        mem_req_wen   <= in_is_store;
                        mem_req_wmask <= in_is_store ? store_mask : 4'b0000;
                        mem_req_wdata <= in_is_store ? store_data : '0;
                    end else begin
                        // Pass-through or fault: the value goes straight to writeback.
                        out_valid <= 1'b1;
                        out_data  <= in_addr;
                        out_wen   <= !fault && (in_rd != 5'd0);
                        out_fault <= fault;
                    end
                end
                REQ: if (mem_req_ready) mem_req_valid <= 1'b0;
                WAIT: if (mem_rsp_valid) begin
                    out_valid <= 1'b1;
                    out_data  <= is_load_q ? load_data : '0;
                    out_wen   <= is_load_q && (out_rd != 5'd0);
                    out_fault <= 1'b0;
                end
                DONE: if (out_ready) out_valid <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: request and result scoreboards fed by the
// stimulus tasks, drained by monitors at the bus and writeback handshakes.
module tb_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, in_is_load, in_is_store;
    logic [2:0]  in_funct3;
    logic [31:0] in_addr, in_wdata;
    logic [4:0]  in_rd;
    logic        mem_req_valid, mem_req_ready, mem_req_wen;
    logic [31:0] mem_req_addr, mem_req_wdata;
    logic [3:0]  mem_req_wmask;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_rdata;
    logic        out_valid, out_ready, out_wen, out_fault;
    logic [31:0] out_data;
    logic [4:0]  out_rd;

    typedef struct {
        logic [31:0] addr;
        logic        wen;
        logic [3:0]  wmask;
        logic [31:0] wdata;
    } req_t;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  rd;
        logic        wen;
        logic        fault;
    } res_t;

    req_t req_q[$];
    res_t res_q[$];
    int   total = 0;
    int   bad   = 0;

    lsu #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_is_load(in_is_load), .in_is_store(in_is_store),
        .in_funct3(in_funct3), .in_addr(in_addr), .in_wdata(in_wdata), .in_rd(in_rd),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_addr(mem_req_addr), .mem_req_wen(mem_req_wen),
        .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_rd(out_rd), .out_wen(out_wen), .out_fault(out_fault)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Bus request monitor: compare each accepted request with the oldest expected one.
    always @(negedge clk) begin
        if (!rst && mem_req_valid && mem_req_ready) begin
            if (req_q.size() == 0) begin
                check("req_unexpected", 32'd1, 32'd0);
            end else begin
                req_t e;
                e = req_q.pop_front();
                check("req_addr", mem_req_addr, e.addr);
                check("req_wen", {31'd0, mem_req_wen}, {31'd0, e.wen});
                check("req_wmask", {28'd0, mem_req_wmask}, {28'd0, e.wmask});
                if (e.wen) check("req_wdata", mem_req_wdata, e.wdata);
            end
        end
    end

    // Writeback monitor: compare each accepted result with the oldest expected one.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (res_q.size() == 0) begin
                check("out_unexpected", 32'd1, 32'd0);
            end else begin
                res_t e;
                e = res_q.pop_front();
                check("out_data", out_data, e.data);
                check("out_rd", {27'd0, out_rd}, {27'd0, e.rd});
                check("out_wen", {31'd0, out_wen}, {31'd0, e.wen});
                check("out_fault", {31'd0, out_fault}, {31'd0, e.fault});
            end
        end
    end

    // One complete operation with optional request and writeback stalls.
    task automatic run_op(
        input logic ld, input logic st, input logic [2:0] f3,
        input logic [31:0] addr, input logic [31:0] wdata, input logic [4:0] rd,
        input logic [31:0] rdata, input logic bus,
        input logic [3:0] exp_mask, input logic [31:0] exp_wdata,
        input logic [31:0] exp_data, input logic exp_wen, input logic exp_fault,
        input int req_stall, input int out_stall
    );
        req_t r;
        res_t o;
        logic [31:0] exp_addr;
        exp_addr = {addr[31:2], 2'b00};
        check("in_ready_idle", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1; in_is_load = ld; in_is_store = st;
        in_funct3 = f3; in_addr = addr; in_wdata = wdata; in_rd = rd;
        o.data = exp_data; o.rd = rd; o.wen = exp_wen; o.fault = exp_fault;
        res_q.push_back(o);
        if (bus) begin
            r.addr = exp_addr; r.wen = st; r.wmask = exp_mask; r.wdata = exp_wdata;
            req_q.push_back(r);
        end
        tick();
        in_valid = 1'b0;
        in_addr  = 32'hA5A5_A5A5;
        in_wdata = 32'h5A5A_5A5A;
        if (bus) begin
            check("req_valid_rise", {31'd0, mem_req_valid}, 32'd1);
            for (int i = 0; i < req_stall; i++) begin
                check("req_stall_valid", {31'd0, mem_req_valid}, 32'd1);
                check("req_stall_addr", mem_req_addr, exp_addr);
                check("req_stall_mask", {28'd0, mem_req_wmask}, {28'd0, exp_mask});
                check("req_stall_in_ready", {31'd0, in_ready}, 32'd0);
                tick();
            end
            mem_req_ready = 1'b1;
            tick();
            mem_req_ready = 1'b0;
            check("req_valid_drop", {31'd0, mem_req_valid}, 32'd0);
            mem_rsp_valid = 1'b1;
            mem_rsp_rdata = rdata;
            tick();
            mem_rsp_valid = 1'b0;
            mem_rsp_rdata = 32'h0;
        end else begin
            check("no_bus_req", {31'd0, mem_req_valid}, 32'd0);
        end
        check("out_valid_lat", {31'd0, out_valid}, 32'd1);
        for (int i = 0; i < out_stall; i++) begin
            check("out_stall_valid", {31'd0, out_valid}, 32'd1);
            check("out_stall_data", out_data, exp_data);
            check("out_stall_in_ready", {31'd0, in_ready}, 32'd0);
            tick();
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("in_ready_after", {31'd0, in_ready}, 32'd1);
        check("out_valid_after", {31'd0, out_valid}, 32'd0);
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
        check({tag, "_req"}, {mem_req_valid, mem_req_wen, 26'd0, mem_req_wmask}, 32'd0);
        check({tag, "_req_addr"}, mem_req_addr, 32'd0);
        check({tag, "_req_wdata"}, mem_req_wdata, 32'd0);
        check({tag, "_out"}, {out_valid, out_wen, out_fault, 24'd0, out_rd}, 32'd0);
        check({tag, "_out_data"}, out_data, 32'd0);
    endtask

    // Watchdog so a stuck run still ends with a report.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        in_valid = 1'b0; in_is_load = 1'b0; in_is_store = 1'b0; in_funct3 = 3'd0;
        in_addr = 32'd0; in_wdata = 32'd0; in_rd = 5'd0;
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_rdata = 32'd0;
        out_ready = 1'b0;
        tick(); tick();
        check_cleared("reset");
        rst = 1'b0;
        tick();

        //     ld    st    f3      addr           wdata          rd     rdata          bus   mask     exp_wdata      exp_data       wen   fault rs os
        run_op(1'b1, 1'b0, 3'b010, 32'h8000_0004, 32'h0,         5'd5,  32'hDEAD_BEEF, 1'b1, 4'b0000, 32'h0,         32'hDEAD_BEEF, 1'b1, 1'b0, 0, 0);
        run_op(1'b1, 1'b0, 3'b000, 32'h8000_0003, 32'h0,         5'd6,  32'h80FF_1234, 1'b1, 4'b0000, 32'h0,         32'hFFFF_FF80, 1'b1, 1'b0, 0, 0);
        run_op(1'b1, 1'b0, 3'b100, 32'h8000_0003, 32'h0,         5'd6,  32'h80FF_1234, 1'b1, 4'b0000, 32'h0,         32'h0000_0080, 1'b1, 1'b0, 0, 0);
        run_op(1'b0, 1'b1, 3'b001, 32'h8000_0002, 32'h0000_ABCD, 5'd7,  32'h1111_2222, 1'b1, 4'b1100, 32'hABCD_ABCD, 32'h0,         1'b0, 1'b0, 0, 0);
        run_op(1'b1, 1'b0, 3'b010, 32'h8000_0002, 32'h0,         5'd8,  32'h0,         1'b0, 4'b0000, 32'h0,         32'h8000_0002, 1'b0, 1'b1, 0, 0);
        run_op(1'b0, 1'b0, 3'b000, 32'h0000_1234, 32'h0,         5'd0,  32'h0,         1'b0, 4'b0000, 32'h0,         32'h0000_1234, 1'b0, 1'b0, 0, 0);
        run_op(1'b0, 1'b0, 3'b010, 32'h0000_0055, 32'h0,         5'd3,  32'h0,         1'b0, 4'b0000, 32'h0,         32'h0000_0055, 1'b1, 1'b0, 0, 0);
        run_op(1'b1, 1'b0, 3'b001, 32'h8000_0002, 32'h0,         5'd9,  32'h8001_7FFF, 1'b1, 4'b0000, 32'h0,         32'hFFFF_8001, 1'b1, 1'b0, 0, 0);
        run_op(1'b1, 1'b0, 3'b101, 32'h8000_0000, 32'h0,         5'd10, 32'h8001_7FFF, 1'b1, 4'b0000, 32'h0,         32'h0000_7FFF, 1'b1, 1'b0, 0, 0);
        run_op(1'b1, 1'b0, 3'b010, 32'h8000_0008, 32'h0,         5'd0,  32'h1357_9BDF, 1'b1, 4'b0000, 32'h0,         32'h1357_9BDF, 1'b0, 1'b0, 0, 0);
        run_op(1'b0, 1'b1, 3'b000, 32'h0000_0011, 32'hFFFF_FF5A, 5'd4,  32'h0,         1'b1, 4'b0010, 32'h5A5A_5A5A, 32'h0,         1'b0, 1'b0, 0, 0);
        run_op(1'b0, 1'b1, 3'b010, 32'h0000_0020, 32'h1234_5678, 5'd4,  32'h0,         1'b1, 4'b1111, 32'h1234_5678, 32'h0,         1'b0, 1'b0, 0, 0);
        run_op(1'b1, 1'b0, 3'b011, 32'h0000_0040, 32'h0,         5'd2,  32'h0,         1'b0, 4'b0000, 32'h0,         32'h0000_0040, 1'b0, 1'b1, 0, 0);
        run_op(1'b1, 1'b1, 3'b000, 32'h0000_0044, 32'h0,         5'd2,  32'h0,         1'b0, 4'b0000, 32'h0,         32'h0000_0044, 1'b0, 1'b1, 0, 0);
        run_op(1'b0, 1'b1, 3'b100, 32'h0000_0048, 32'h0,         5'd2,  32'h0,         1'b0, 4'b0000, 32'h0,         32'h0000_0048, 1'b0, 1'b1, 0, 0);
        run_op(1'b1, 1'b0, 3'b001, 32'h0000_0001, 32'h0,         5'd2,  32'h0,         1'b0, 4'b0000, 32'h0,         32'h0000_0001, 1'b0, 1'b1, 0, 0);
        // Stalled request and stalled writeback.
        run_op(1'b1, 1'b0, 3'b010, 32'h8000_0010, 32'h0,         5'd11, 32'hCAFE_F00D, 1'b1, 4'b0000, 32'h0,         32'hCAFE_F00D, 1'b1, 1'b0, 3, 2);
        run_op(1'b0, 1'b1, 3'b000, 32'h8000_0013, 32'h0000_00C3, 5'd12, 32'h0,         1'b1, 4'b1000, 32'hC3C3_C3C3, 32'h0,         1'b0, 1'b0, 3, 2);

        // Reset while waiting for the response: the late response must be dropped.
        begin
            req_t r;
            check("in_ready_idle", {31'd0, in_ready}, 32'd1);
            in_valid = 1'b1; in_is_load = 1'b1; in_is_store = 1'b0;
            in_funct3 = 3'b010; in_addr = 32'h8000_0030; in_rd = 5'd13;
            r.addr = 32'h8000_0030; r.wen = 1'b0; r.wmask = 4'b0000; r.wdata = 32'h0;
            req_q.push_back(r);
            tick();
            in_valid = 1'b0;
            mem_req_ready = 1'b1;
            tick();
            mem_req_ready = 1'b0;
            #2 rst = 1'b1;
            #2 check_cleared("rst_wait");
            @(posedge clk);
            #1 rst = 1'b0;
            mem_rsp_valid = 1'b1;
            mem_rsp_rdata = 32'h7777_7777;
            tick();
            mem_rsp_valid = 1'b0;
            out_ready = 1'b1;
            for (int i = 0; i < 4; i++) begin
                check("rst_no_out_valid", {31'd0, out_valid}, 32'd0);
                check("rst_in_ready", {31'd0, in_ready}, 32'd1);
                tick();
            end
            out_ready = 1'b0;
        end

        check("req_queue_empty", req_q.size(), 32'd0);
        check("res_queue_empty", res_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
